// File: rtl/fx_scoreboard_regfile_pkg.sv
// rtl/fx_scoreboard_regfile_pkg.sv - shared defaults, slot indices and width helper for the scoreboard regfile
package fx_scoreboard_regfile_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_REG_AW = 5;
  localparam int DEF_NUM_RD = 3;
  localparam int DEF_NUM_WB = 2;
  localparam int DEF_PEND_W = 2;
  localparam int DEF_BYPASS = 1;

  localparam int SLOT_RS1 = 0;
  localparam int SLOT_RS2 = 1;
  localparam int SLOT_RS3 = 2;

  // Bits needed to hold a count of 0..n hits in one cycle.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fx_scoreboard_regfile_if.sv
// rtl/fx_scoreboard_regfile_if.sv - issue, operand and writeback bundle between sequencer and scoreboard
interface fx_scoreboard_regfile_if
  import fx_scoreboard_regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW,
  parameter int NUM_RD = DEF_NUM_RD,
  parameter int NUM_WB = DEF_NUM_WB
);
  logic                     issue_valid_i;
  logic                     issue_ready_o;
  logic [NUM_RD-1:0]        src_en_i;
  logic [NUM_RD-1:0]        src_zero_i;
  logic [NUM_RD-1:0]        dst_en_i;
  logic [NUM_RD*REG_AW-1:0] slot_addr_i;
  logic                     out_valid_o;
  logic [NUM_RD*DATA_W-1:0] operand_o;
  logic [NUM_RD-1:0]        dst_en_o;
  logic [NUM_RD*REG_AW-1:0] dst_addr_o;
  logic [NUM_WB-1:0]        wb_en_i;
  logic [NUM_WB*REG_AW-1:0] wb_addr_i;
  logic [NUM_WB*DATA_W-1:0] wb_data_i;

  modport master (
    output issue_valid_i, src_en_i, src_zero_i, dst_en_i, slot_addr_i,
    output wb_en_i, wb_addr_i, wb_data_i,
    input  issue_ready_o, out_valid_o, operand_o, dst_en_o, dst_addr_o
  );

  modport slave (
    input  issue_valid_i, src_en_i, src_zero_i, dst_en_i, slot_addr_i,
    input  wb_en_i, wb_addr_i, wb_data_i,
    output issue_ready_o, out_valid_o, operand_o, dst_en_o, dst_addr_o
  );

endinterface

// File: rtl/fx_scoreboard_regfile_pend_ctr.sv
// rtl/fx_scoreboard_regfile_pend_ctr.sv - fx_pend_ctr: one register's saturating pending-write counter
module fx_pend_ctr
  import fx_scoreboard_regfile_pkg::*;
#(
  parameter int PEND_W = DEF_PEND_W,
  parameter int INC_W  = 2,
  parameter int DEC_W  = 2
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              flush_i,
  input  logic              take_i,
  input  logic [INC_W-1:0]  inc_i,
  input  logic [DEC_W-1:0]  dec_i,
  output logic [PEND_W-1:0] cnt_o,
  output logic              ovf_o,
  output logic              under_o
);
  localparam int MAX_CNT = (1 << PEND_W) - 1;

  logic [PEND_W-1:0] cnt_q, cnt_d;
  int drained, raised;

  // Writebacks only retire writes already outstanding; surplus ones are reported, not borrowed.
  always_comb begin
    under_o = int'(dec_i) > int'(cnt_q);
    drained = under_o ? 0 : int'(cnt_q) - int'(dec_i);
    raised  = drained + int'(inc_i);
    ovf_o   = raised > MAX_CNT;
    cnt_d   = PEND_W'(drained);
    if (flush_i) begin
      cnt_d = '0;
    end else if (take_i) begin
      cnt_d = ovf_o ? PEND_W'(MAX_CNT) : PEND_W'(raised);
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fx_scoreboard_regfile.sv
// rtl/fx_scoreboard_regfile.sv - register file with per-register pending-write scoreboard and writeback bypass
module fx_scoreboard_regfile
  import fx_scoreboard_regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW,
  parameter int NUM_RD = DEF_NUM_RD,
  parameter int NUM_WB = DEF_NUM_WB,
  parameter int PEND_W = DEF_PEND_W,
  parameter int BYPASS = DEF_BYPASS
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  fx_scoreboard_regfile_if.slave bus,
  input  logic                   flush_i,
  input  logic                   dbg_en_i,
  input  logic [REG_AW-1:0]      dbg_addr_i,
  output logic [DATA_W-1:0]      dbg_data_o,
  output logic                   wb_err_o
);
  localparam int NUM_REGS = 1 << REG_AW;
  localparam int INC_W    = cnt_w(NUM_RD);
  localparam int DEC_W    = cnt_w(NUM_WB);

  logic [DATA_W-1:0] rf_q [NUM_REGS];
  logic [REG_AW-1:0] slot_addr [NUM_RD];
  logic [REG_AW-1:0] wb_addr [NUM_WB];
  logic [DATA_W-1:0] wb_data [NUM_WB];
  logic [INC_W-1:0]  inc_req [NUM_REGS];
  logic [DEC_W-1:0]  dec_cnt [NUM_REGS];
  logic [PEND_W-1:0] cnt [NUM_REGS];
  logic [NUM_REGS-1:0] ovf, under;
  logic [NUM_RD-1:0] zero_rd, slot_haz;
  logic              ready, accept;
  logic [NUM_RD*DATA_W-1:0] op_d;

  logic                     out_valid_q;
  logic [NUM_RD*DATA_W-1:0] operand_q;
  logic [NUM_RD-1:0]        dst_en_q;
  logic [NUM_RD*REG_AW-1:0] dst_addr_q;
  logic [DATA_W-1:0]        dbg_q;
  logic                     wb_err_q;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_slot
    assign slot_addr[i] = bus.slot_addr_i[i*REG_AW +: REG_AW];
    assign zero_rd[i]   = bus.src_zero_i[i] && (slot_addr[i] == '0);
    // A pending source is still safe when every outstanding write lands this cycle.
    assign slot_haz[i]  = bus.src_en_i[i] && (cnt[slot_addr[i]] != '0) && !zero_rd[i] &&
                          !((BYPASS != 0) && (int'(cnt[slot_addr[i]]) == int'(dec_cnt[slot_addr[i]])));
  end

  for (genvar w = 0; w < NUM_WB; w++) begin : g_wb
    assign wb_addr[w] = bus.wb_addr_i[w*REG_AW +: REG_AW];
    assign wb_data[w] = bus.wb_data_i[w*DATA_W +: DATA_W];
  end

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      inc_req[r] = '0;
      dec_cnt[r] = '0;
    end
    for (int i = 0; i < NUM_RD; i++) begin
      if (bus.dst_en_i[i]) inc_req[slot_addr[i]] = inc_req[slot_addr[i]] + INC_W'(1);
    end
    for (int w = 0; w < NUM_WB; w++) begin
      if (bus.wb_en_i[w]) dec_cnt[wb_addr[w]] = dec_cnt[wb_addr[w]] + DEC_W'(1);
    end
  end

  assign ready  = !(|slot_haz) && !(|ovf) && !reset_i;
  assign accept = bus.issue_valid_i && ready && !flush_i;

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_ctr
    fx_pend_ctr #(.PEND_W(PEND_W), .INC_W(INC_W), .DEC_W(DEC_W)) u_ctr (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .flush_i (flush_i),
      .take_i  (accept),
      .inc_i   (inc_req[r]),
      .dec_i   (dec_cnt[r]),
      .cnt_o   (cnt[r]),
      .ovf_o   (ovf[r]),
      .under_o (under[r])
    );
  end

  // Later writeback ports override earlier ones, matching the store order below.
  always_comb begin
    op_d = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (bus.src_en_i[i] && !zero_rd[i]) begin
        op_d[i*DATA_W +: DATA_W] = rf_q[slot_addr[i]];
        if (BYPASS != 0) begin
          for (int w = 0; w < NUM_WB; w++) begin
            if (bus.wb_en_i[w] && (wb_addr[w] == slot_addr[i])) op_d[i*DATA_W +: DATA_W] = wb_data[w];
          end
        end
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int r = 0; r < NUM_REGS; r++) rf_q[r] <= '0;
    end else begin
      for (int w = 0; w < NUM_WB; w++) begin
        if (bus.wb_en_i[w]) rf_q[wb_addr[w]] <= wb_data[w];
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      out_valid_q <= 1'b0;
      operand_q   <= '0;
      dst_en_q    <= '0;
      dst_addr_q  <= '0;
      dbg_q       <= '0;
      wb_err_q    <= 1'b0;
    end else begin
      out_valid_q <= accept;
      wb_err_q    <= |under;
      if (accept) begin
        operand_q  <= op_d;
        dst_en_q   <= bus.dst_en_i;
        dst_addr_q <= bus.slot_addr_i;
      end
      if (dbg_en_i) dbg_q <= rf_q[dbg_addr_i];
    end
  end

  assign bus.issue_ready_o = ready;
  assign bus.out_valid_o   = out_valid_q;
  assign bus.operand_o     = operand_q;
  assign bus.dst_en_o      = dst_en_q;
  assign bus.dst_addr_o    = dst_addr_q;
  assign dbg_data_o        = dbg_q;
  assign wb_err_o          = wb_err_q;

endmodule

// File: tb/tb_fx_scoreboard_regfile.sv
// tb/tb_fx_scoreboard_regfile.sv - randomized and directed bench for fx_scoreboard_regfile
module tb_fx_scoreboard_regfile;
  import fx_scoreboard_regfile_pkg::*;

  localparam int DW = 64, AW = 5, NRD = 3, NWB = 2, PW = 2, BYP = 1;
  localparam int NREG = 32, MAXC = 3;

  logic clk = 1'b0;
  logic rst, flush, dbg_en;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_data;
  logic wb_err;

  fx_scoreboard_regfile_if #(.DATA_W(DW), .REG_AW(AW), .NUM_RD(NRD), .NUM_WB(NWB)) bus ();

  fx_scoreboard_regfile #(.DATA_W(DW), .REG_AW(AW), .NUM_RD(NRD), .NUM_WB(NWB),
                          .PEND_W(PW), .BYPASS(BYP)) dut (
    .clock_i(clk), .reset_i(rst), .bus(bus), .flush_i(flush),
    .dbg_en_i(dbg_en), .dbg_addr_i(dbg_addr), .dbg_data_o(dbg_data), .wb_err_o(wb_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_miss = 0;
  bit chk_en = 1'b0;

  int            m_cnt [NREG], n_cnt [NREG];
  logic [DW-1:0] m_rf [NREG], n_rf [NREG];
  bit            e_ready;
  bit            e_ov, n_ov, e_err, n_errb;
  logic [DW-1:0] e_op [NRD], n_op [NRD];
  logic [NRD-1:0] e_den, n_den;
  logic [NRD*AW-1:0] e_dad, n_dad;
  logic [DW-1:0] e_dbg, n_dbg;

  function automatic int saddr(input int i);
    return int'(bus.slot_addr_i[i*AW +: AW]);
  endfunction
  function automatic int waddr(input int w);
    return int'(bus.wb_addr_i[w*AW +: AW]);
  endfunction
  function automatic logic [DW-1:0] wdata(input int w);
    return bus.wb_data_i[w*DW +: DW];
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: counts of outstanding writes per register and a plain array for the file.
  task automatic model_eval();
    int hits [NREG];
    int incs [NREG];
    bit hz, blk, acc;
    for (int r = 0; r < NREG; r++) begin hits[r] = 0; incs[r] = 0; end
    for (int w = 0; w < NWB; w++) if (bus.wb_en_i[w]) hits[waddr(w)]++;
    for (int i = 0; i < NRD; i++) if (bus.dst_en_i[i]) incs[saddr(i)]++;
    hz = 0;
    for (int i = 0; i < NRD; i++) begin
      int a;
      a = saddr(i);
      if (bus.src_en_i[i] && m_cnt[a] != 0 && !(bus.src_zero_i[i] && a == 0) &&
          !(BYP == 1 && m_cnt[a] == hits[a])) hz = 1;
    end
    blk = 0;
    for (int r = 0; r < NREG; r++) if (m_cnt[r] + incs[r] - hits[r] > MAXC) blk = 1;
    e_ready = !hz && !blk && !rst;
    acc = bus.issue_valid_i && e_ready && !flush;
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin n_cnt[r] = 0; n_rf[r] = '0; end
      for (int i = 0; i < NRD; i++) n_op[i] = '0;
      n_ov = 0; n_den = '0; n_dad = '0; n_dbg = '0; n_errb = 0;
    end else begin
      n_errb = 0;
      for (int r = 0; r < NREG; r++) begin
        n_rf[r] = m_rf[r];
        if (hits[r] > m_cnt[r]) n_errb = 1;
        n_cnt[r] = flush ? 0 : ((m_cnt[r] > hits[r]) ? m_cnt[r] - hits[r] : 0) + (acc ? incs[r] : 0);
      end
      for (int w = 0; w < NWB; w++) if (bus.wb_en_i[w]) n_rf[waddr(w)] = wdata(w);
      n_ov = acc;
      n_den = acc ? bus.dst_en_i : e_den;
      n_dad = acc ? bus.slot_addr_i : e_dad;
      for (int i = 0; i < NRD; i++) begin
        logic [DW-1:0] v;
        int a;
        a = saddr(i);
        v = '0;
        if (bus.src_en_i[i] && !(bus.src_zero_i[i] && a == 0)) begin
          v = m_rf[a];
          for (int w = 0; w < NWB; w++) if (bus.wb_en_i[w] && waddr(w) == a) v = wdata(w);
        end
        n_op[i] = acc ? v : e_op[i];
      end
      n_dbg = dbg_en ? m_rf[dbg_addr] : e_dbg;
    end
  endtask

  task automatic commit();
    m_cnt = n_cnt;
    m_rf  = n_rf;
    e_ov = n_ov; e_op = n_op; e_den = n_den; e_dad = n_dad; e_dbg = n_dbg; e_err = n_errb;
  endtask

  task automatic cycle();
    model_eval();
    @(posedge clk);
    #1;
    commit();
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clr();
    bus.issue_valid_i = 0; bus.src_en_i = '0; bus.src_zero_i = '0; bus.dst_en_i = '0;
    bus.slot_addr_i = '0; bus.wb_en_i = '0; bus.wb_addr_i = '0; bus.wb_data_i = '0;
    flush = 0; dbg_en = 0; dbg_addr = '0;
  endtask

  task automatic slot(input int i, input bit s, input bit z, input bit d, input int a);
    bus.src_en_i[i] = s; bus.src_zero_i[i] = z; bus.dst_en_i[i] = d;
    bus.slot_addr_i[i*AW +: AW] = AW'(a);
  endtask

  task automatic wb(input int w, input int a, input logic [DW-1:0] d);
    bus.wb_en_i[w] = 1'b1;
    bus.wb_addr_i[w*AW +: AW] = AW'(a);
    bus.wb_data_i[w*DW +: DW] = d;
  endtask

  function automatic int rnd_addr();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NREG - 1)) : int'($urandom_range(0, 7));
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("issue_ready", {63'b0, bus.issue_ready_o}, {63'b0, e_ready});
      chk("out_valid", {63'b0, bus.out_valid_o}, {63'b0, e_ov});
      chk("wb_err", {63'b0, wb_err}, {63'b0, e_err});
      chk("dbg_data", dbg_data, e_dbg);
      if (e_ov) begin
        for (int i = 0; i < NRD; i++) chk($sformatf("operand%0d", i), bus.operand_o[i*DW +: DW], e_op[i]);
        chk("dst_en", {61'b0, bus.dst_en_o}, {61'b0, e_den});
        chk("dst_addr", {49'b0, bus.dst_addr_o}, {49'b0, e_dad});
      end
    end
  end

  initial begin
    rst = 1; clr();
    cycle();
    chk_en = 1;
    cycle();
    chk("reset out_valid", {63'b0, bus.out_valid_o}, 64'd0);
    chk("reset dbg", dbg_data, 64'd0);
    rst = 0;

    // dst r5, then a stalled reader released by a same-cycle writeback
    clr(); bus.issue_valid_i = 1; slot(SLOT_RS1, 0, 0, 1, 5); settle();
    chk("r5 first issue ready", {63'b0, bus.issue_ready_o}, 64'd1);
    cycle();
    clr(); bus.issue_valid_i = 1; slot(SLOT_RS1, 1, 0, 0, 5); settle();
    chk("r5 stall", {63'b0, bus.issue_ready_o}, 64'd0);
    cycle(); settle();
    chk("r5 stall hold", {63'b0, bus.issue_ready_o}, 64'd0);
    cycle();
    wb(0, 5, 64'hAB); settle();
    chk("r5 bypass ready", {63'b0, bus.issue_ready_o}, 64'd1);
    cycle();
    chk("r5 out_valid", {63'b0, bus.out_valid_o}, 64'd1);
    chk("r5 operand", bus.operand_o[SLOT_RS1*DW +: DW], 64'hAB);

    // r3 pending count limit
    clr(); bus.issue_valid_i = 1; slot(SLOT_RS1, 0, 0, 1, 3); cycle(); cycle();
    slot(SLOT_RS2, 0, 0, 1, 3); slot(SLOT_RS3, 0, 0, 1, 3); settle();
    chk("r3 over limit", {63'b0, bus.issue_ready_o}, 64'd0);
    cycle();
    clr(); bus.issue_valid_i = 1; slot(SLOT_RS1, 0, 0, 1, 3); settle();
    chk("r3 third ready", {63'b0, bus.issue_ready_o}, 64'd1);
    cycle(); settle();
    chk("r3 fourth blocked", {63'b0, bus.issue_ready_o}, 64'd0);
    cycle();
    clr(); wb(0, 3, 64'h1); wb(1, 3, 64'h2); cycle();
    clr(); wb(0, 3, 64'h3); cycle();
    clr(); bus.issue_valid_i = 1; slot(SLOT_RS1, 1, 0, 0, 3); settle();
    chk("r3 drained", {63'b0, bus.issue_ready_o}, 64'd1);
    cycle();

    // r7 double writeback
    clr(); bus.issue_valid_i = 1; slot(SLOT_RS1, 0, 0, 1, 7); slot(SLOT_RS2, 0, 0, 1, 7); cycle();
    clr(); wb(0, 7, 64'h11); wb(1, 7, 64'h22); cycle();
    chk("r7 no err", {63'b0, wb_err}, 64'd0);
    clr(); bus.issue_valid_i = 1; slot(SLOT_RS1, 1, 0, 0, 7); dbg_en = 1; dbg_addr = 7; settle();
    chk("r7 ready", {63'b0, bus.issue_ready_o}, 64'd1);
    cycle();
    chk("r7 operand", bus.operand_o[SLOT_RS1*DW +: DW], 64'h22);
    chk("r7 dbg", dbg_data, 64'h22);

    // zero-read of pending r0
    clr(); wb(0, 0, 64'h55); cycle();
    clr(); bus.issue_valid_i = 1; slot(SLOT_RS1, 0, 0, 1, 0); cycle();
    clr(); bus.issue_valid_i = 1; slot(SLOT_RS1, 1, 0, 0, 0); settle();
    chk("r0 plain stall", {63'b0, bus.issue_ready_o}, 64'd0);
    slot(SLOT_RS1, 1, 1, 0, 0); settle();
    chk("r0 zero ready", {63'b0, bus.issue_ready_o}, 64'd1);
    cycle();
    chk("r0 zero operand", bus.operand_o[SLOT_RS1*DW +: DW], 64'd0);

    // writeback to idle r9
    clr(); wb(1, 9, 64'h99); cycle();
    chk("r9 err pulse", {63'b0, wb_err}, 64'd1);
    clr(); dbg_en = 1; dbg_addr = 9; cycle();
    chk("r9 err clear", {63'b0, wb_err}, 64'd0);
    chk("r9 dbg", dbg_data, 64'h99);

    // flush, then reset while stalled
    clr(); bus.issue_valid_i = 1; slot(SLOT_RS1, 0, 0, 1, 12); cycle();
    clr(); bus.issue_valid_i = 1; flush = 1; slot(SLOT_RS1, 0, 0, 1, 20); cycle();
    chk("flush no accept", {63'b0, bus.out_valid_o}, 64'd0);
    clr(); bus.issue_valid_i = 1; slot(SLOT_RS1, 1, 0, 0, 12); slot(SLOT_RS2, 1, 0, 0, 0); settle();
    chk("post flush ready", {63'b0, bus.issue_ready_o}, 64'd1);
    cycle();
    clr(); bus.issue_valid_i = 1; slot(SLOT_RS1, 0, 0, 1, 5); cycle();
    clr(); bus.issue_valid_i = 1; slot(SLOT_RS1, 1, 0, 0, 5); settle();
    chk("r5 stall again", {63'b0, bus.issue_ready_o}, 64'd0);
    cycle();
    rst = 1; settle();
    chk("reset ready low", {63'b0, bus.issue_ready_o}, 64'd0);
    cycle();
    chk("reset out_valid low", {63'b0, bus.out_valid_o}, 64'd0);
    rst = 0; dbg_en = 1; dbg_addr = 7; settle();
    chk("reset cleared counters", {63'b0, bus.issue_ready_o}, 64'd1);
    cycle();
    chk("reset cleared file", dbg_data, 64'd0);

    for (int n = 0; n < 3000; n++) begin
      clr();
      rst = ($urandom_range(0, 149) == 0);
      flush = ($urandom_range(0, 39) == 0);
      bus.issue_valid_i = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NRD; i++)
        slot(i, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), rnd_addr());
      for (int w = 0; w < NWB; w++)
        if ($urandom_range(0, 1) == 1) wb(w, rnd_addr(), {$urandom(), $urandom()});
      dbg_en = ($urandom_range(0, 2) == 0);
      dbg_addr = AW'($urandom_range(0, NREG - 1));
      cycle();
    end

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
